// File: rtl/router_pkg.sv
// Shared definitions for the router output arbiter.
// Holds the arbiter state encoding, the port count, the default stall
// timeout, the grant code shown while idle, and two small helpers: the
// modulo-3 port increment and the running-XOR parity fold.
package router_pkg;

    localparam int         NUM_PORTS       = 3;
    localparam int         TIMEOUT_DEFAULT = 32;
    localparam logic [1:0] GRANT_IDLE      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_RD   = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Next port index, wrapping 2 -> 0 (any out-of-range code also maps to 0).
    function automatic logic [1:0] next_port(input logic [1:0] p);
        next_port = (p >= 2'd2) ? 2'd0 : (p + 2'd1);
    endfunction

    // Folds one byte into the running packet parity.
    function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
        parity_fold = acc ^ b;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Round-robin port picker (purely combinational).
// Ports:
//   empty[2:0] in  : empty flags of the three output FIFOs
//   rr_ptr     in  : port with highest priority this round
//   pick       out : first non-empty port at or after rr_ptr (mod 3)
//   valid      out : 1 when at least one FIFO is non-empty
module router_rr_pick
    import router_pkg::*;
(
    input  logic [2:0] empty,
    input  logic [1:0] rr_ptr,
    output logic [1:0] pick,
    output logic       valid
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    // Search order rr_ptr, rr_ptr+1, rr_ptr+2; an illegal pointer behaves as 0.
    always_comb begin
        cand0 = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
        cand1 = next_port(cand0);
        cand2 = next_port(cand1);
        pick  = 2'd0;
        valid = 1'b0;
        if (!empty[cand0]) begin
            pick  = cand0;
            valid = 1'b1;
        end else if (!empty[cand1]) begin
            pick  = cand1;
            valid = 1'b1;
        end else if (!empty[cand2]) begin
            pick  = cand2;
            valid = 1'b1;
        end else begin
            pick  = 2'd0;
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/router_out_arb.sv
// Output arbiter of the router: picks one of three output FIFOs round-robin,
// streams one whole packet (header, header[7:2] payload bytes, parity byte)
// to the downstream link, checks the packet parity and aborts packets whose
// FIFO stays empty for TIMEOUT consecutive cycles.
// Ports:
//   clock, resetn                 : clock, synchronous active-low reset
//   fifo_empty_n, fifo_dout_n     : FIFO n status and read data (1-cycle latency)
//   link_ready                    : downstream can accept a byte this cycle
//   read_enb_n                    : read strobe to FIFO n (one-hot or zero)
//   data_out, vld_out             : byte to the link and its valid flag
//   grant                         : granted FIFO, 2'b11 while idle
//   parity_err                    : pulse in DONE when the parity byte mismatches
//   soft_reset_n                  : pulse that aborts a stalled packet on FIFO n
module router_out_arb
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic [7:0] fifo_dout_0,
    input  logic [7:0] fifo_dout_1,
    input  logic [7:0] fifo_dout_2,
    input  logic       link_ready,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] data_out,
    output logic       vld_out,
    output logic [1:0] grant,
    output logic       parity_err,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [7:0]    acc_q, acc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          vld_q, vld_d;

    logic [2:0]    empty_vec;
    logic          empty_g;
    logic [7:0]    dout_g;
    logic          rd_g;
    logic          timeout_hit;
    logic [1:0]    pick;
    logic          pick_valid;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};

    router_rr_pick u_rr_pick (
        .empty  (empty_vec),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .valid  (pick_valid)
    );

    // Status and data of the granted FIFO; with no grant it looks empty.
    always_comb begin
        empty_g = 1'b1;
        dout_g  = 8'h00;
        case (grant_q)
            2'd0:    begin empty_g = fifo_empty_0; dout_g = fifo_dout_0; end
            2'd1:    begin empty_g = fifo_empty_1; dout_g = fifo_dout_1; end
            2'd2:    begin empty_g = fifo_empty_2; dout_g = fifo_dout_2; end
            default: begin empty_g = 1'b1;         dout_g = 8'h00;       end
        endcase
    end

    // cnt covers payload plus the parity byte, so reads stop once it hits 0.
    assign rd_g = link_ready & ~empty_g &
                  ((state_q == ST_HDR_RD) | ((state_q == ST_PAYLOAD) & (cnt_q != 7'd0)));

    // Fires on the TIMEOUT-th consecutive empty cycle of the payload phase.
    assign timeout_hit = (state_q == ST_PAYLOAD) & empty_g & (tmo_q == TMO_LAST);

    assign read_enb_0   = rd_g & (grant_q == 2'd0);
    assign read_enb_1   = rd_g & (grant_q == 2'd1);
    assign read_enb_2   = rd_g & (grant_q == 2'd2);
    assign soft_reset_0 = timeout_hit & (grant_q == 2'd0);
    assign soft_reset_1 = timeout_hit & (grant_q == 2'd1);
    assign soft_reset_2 = timeout_hit & (grant_q == 2'd2);

    // FIFO data arrives one cycle after the strobe, i.e. together with vld_q.
    assign vld_out    = vld_q;
    assign data_out   = vld_q ? dout_g : 8'h00;
    assign grant      = grant_q;
    assign parity_err = (state_q == ST_DONE) & vld_q & (dout_g != acc_q);

    // Next-state logic of the packet FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        tmo_d    = {TW{1'b0}};
        vld_d    = rd_g;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ST_HDR_RD;
                end else begin
                    grant_d = GRANT_IDLE;
                end
            end
            ST_HDR_RD: begin
                if (rd_g) begin
                    state_d = ST_HDR_WAIT;
                end else begin
                    state_d = ST_HDR_RD;
                end
            end
            ST_HDR_WAIT: begin
                cnt_d   = {1'b0, dout_g[7:2]} + 7'd1;
                acc_d   = dout_g;
                state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                // Only payload bytes can be valid here; parity lands in DONE.
                if (vld_q) begin
                    acc_d = parity_fold(acc_q, dout_g);
                end else begin
                    acc_d = acc_q;
                end
                if (timeout_hit) begin
                    state_d  = ST_IDLE;
                    grant_d  = GRANT_IDLE;
                    rr_ptr_d = next_port(grant_q);
                end else if (rd_g) begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (empty_g) begin
                    tmo_d = tmo_q + TW'(1);
                end else begin
                    tmo_d = {TW{1'b0}};
                end
            end
            ST_DONE: begin
                rr_ptr_d = next_port(grant_q);
                grant_d  = GRANT_IDLE;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= GRANT_IDLE;
            rr_ptr_q <= 2'd0;
            cnt_q    <= 7'd0;
            acc_q    <= 8'h00;
            tmo_q    <= {TW{1'b0}};
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_router_out_arb.sv
// Directed self-checking bench for router_out_arb: three behavioural FIFOs
// with one-cycle read latency feed the DUT and a negedge monitor logs the
// byte stream, grants, parity errors and soft resets for the test tasks.
module tb_router_out_arb;

    logic       clock = 1'b0;
    logic       resetn;
    logic       link_ready;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [7:0] fifo_dout_0 = 8'h00;
    logic [7:0] fifo_dout_1 = 8'h00;
    logic [7:0] fifo_dout_2 = 8'h00;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] data_out;
    logic       vld_out;
    logic [1:0] grant;
    logic       parity_err;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    router_out_arb #(.TIMEOUT(32)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .fifo_dout_0  (fifo_dout_0),
        .fifo_dout_1  (fifo_dout_1),
        .fifo_dout_2  (fifo_dout_2),
        .link_ready   (link_ready),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .data_out     (data_out),
        .vld_out      (vld_out),
        .grant        (grant),
        .parity_err   (parity_err),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    // ---------------- FIFO models ----------------
    logic [7:0] mem [3][256];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};
    logic       flush = 1'b0;

    assign fifo_empty_0 = (wp[0] == rp[0]);
    assign fifo_empty_1 = (wp[1] == rp[1]);
    assign fifo_empty_2 = (wp[2] == rp[2]);

    // Registered FIFO read port; flush drops everything still queued.
    always @(posedge clock) begin
        if (flush) begin
            rp[0] <= wp[0];
            rp[1] <= wp[1];
            rp[2] <= wp[2];
        end else begin
            if (read_enb_0 && wp[0] != rp[0]) begin fifo_dout_0 <= mem[0][rp[0] & 255]; rp[0] <= rp[0] + 1; end
            if (read_enb_1 && wp[1] != rp[1]) begin fifo_dout_1 <= mem[1][rp[1] & 255]; rp[1] <= rp[1] + 1; end
            if (read_enb_2 && wp[2] != rp[2]) begin fifo_dout_2 <= mem[2][rp[2] & 255]; rp[2] <= rp[2] + 1; end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] cap  [512];
    logic [1:0] capg [512];
    int         cap_n = 0;
    logic [1:0] glog [64];
    int         gl_n = 0;
    logic [1:0] prev_grant = 2'b11;
    int         perr_n = 0;
    logic [7:0] perr_byte = 8'h00;
    int         sr_n [3] = '{0, 0, 0};
    int         sr_cyc = 0;
    int         e2_rise = 0;
    logic       prev_e2 = 1'b1;
    int         viol = 0;
    logic       prev_rd = 1'b0;
    int         cyc = 0;
    logic [2:0] rd_vec;

    assign rd_vec = {read_enb_2, read_enb_1, read_enb_0};

    // Samples DUT outputs mid-cycle and logs events for the test tasks.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (vld_out) begin
            cap[cap_n & 511]  <= data_out;
            capg[cap_n & 511] <= grant;
            cap_n             <= cap_n + 1;
        end
        if (grant != 2'b11 && prev_grant == 2'b11) begin
            glog[gl_n & 63] <= grant;
            gl_n            <= gl_n + 1;
        end
        prev_grant <= grant;
        if (parity_err) begin
            perr_n    <= perr_n + 1;
            perr_byte <= data_out;
        end
        if (soft_reset_0) sr_n[0] <= sr_n[0] + 1;
        if (soft_reset_1) sr_n[1] <= sr_n[1] + 1;
        if (soft_reset_2) begin
            sr_n[2] <= sr_n[2] + 1;
            sr_cyc  <= cyc;
        end
        if (fifo_empty_2 && !prev_e2) e2_rise <= cyc;
        prev_e2 <= fifo_empty_2;
        // Strobe sanity: one-hot, only with link_ready, vld_out echoes last cycle's read.
        if (($countones(rd_vec) > 1) || ((|rd_vec) && !link_ready) || (vld_out != prev_rd))
            viol <= viol + 1;
        prev_rd <= (|rd_vec) && resetn;
    end

    // ---------------- helpers ----------------
    logic [7:0] pkt_bytes [64];
    int         pkt_len = 0;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Builds a packet into pkt_bytes and queues its first `keep` bytes (all if keep < 0).
    task automatic push_pkt(input int port, input logic [7:0] hdr, input logic [7:0] seed,
                            input logic corrupt, input int keep);
        logic [7:0] p;
        int         len;
        int         n;
        len          = int'(hdr[7:2]);
        pkt_len      = len + 2;
        pkt_bytes[0] = hdr;
        p            = hdr;
        for (int i = 1; i <= len; i++) begin
            pkt_bytes[i] = seed + 8'(i * 37);
            p            = p ^ pkt_bytes[i];
        end
        pkt_bytes[len + 1] = corrupt ? ~p : p;
        n = (keep < 0) ? pkt_len : keep;
        for (int i = 0; i < n; i++) mem[port][(wp[port] + i) & 255] = pkt_bytes[i];
        wp[port] = wp[port] + n;
    endtask

    task automatic wait_bytes(input int target, input string tag);
        for (int k = 0; k < 200; k++) begin
            if (cap_n >= target) break;
            step();
        end
        n_cmp++;
        if (cap_n < target) begin
            n_bad++;
            $display("FAIL %s_wait: got %0d bytes want %0d", tag, cap_n, target);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic check_bytes(input int s, input string tag);
        for (int i = 0; i < pkt_len; i++) begin
            n_cmp++;
            if (cap[(s + i) & 511] !== pkt_bytes[i]) begin
                n_bad++;
                $display("FAIL %s_byte%0d: got %h want %h", tag, i, cap[(s + i) & 511], pkt_bytes[i]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if ({vld_out, grant, data_out, parity_err, rd_vec, soft_reset_2, soft_reset_1, soft_reset_0}
            !== {1'b0, 2'b11, 8'h00, 1'b0, 3'b000, 3'b000}) begin
            n_bad++;
            $display("FAIL %s: got vld=%b grant=%b data=%h perr=%b rd=%b sr=%b%b%b want 0/11/00/0/000/000",
                     tag, vld_out, grant, data_out, parity_err, rd_vec,
                     soft_reset_2, soft_reset_1, soft_reset_0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn     = 1'b0;
        link_ready = 1'b1;
        repeat (3) step();
        check_idle_outputs("reset_state");
        resetn = 1'b1;
        step();
        check_idle_outputs("after_reset_idle");
    endtask

    task automatic test_single();
        int s, g0, pe;
        s  = cap_n;
        g0 = gl_n;
        pe = perr_n;
        push_pkt(1, 8'h0D, 8'h10, 1'b0, -1);
        wait_bytes(s + 5, "single");
        step();
        step();
        check_bytes(s, "single");
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (capg[(s + i) & 511] !== 2'd1) begin
                n_bad++;
                $display("FAIL single_grant%0d: got %0d want 1", i, capg[(s + i) & 511]);
            end
        end
        n_cmp++;
        if (cap_n != s + 5 || gl_n != g0 + 1 || perr_n != pe) begin
            n_bad++;
            $display("FAIL single_counts: got bytes=%0d grants=%0d perr=%0d want 5/1/0",
                     cap_n - s, gl_n - g0, perr_n - pe);
        end
        n_cmp++;
        if (grant !== 2'b11) begin
            n_bad++;
            $display("FAIL single_end_grant: got %b want 11", grant);
        end
    endtask

    task automatic test_round_robin();
        int         s, g0, pe;
        logic [1:0] exp_g [6];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        do_reset();
        s  = cap_n;
        g0 = gl_n;
        pe = perr_n;
        for (int r = 0; r < 2; r++) begin
            push_pkt(2, 8'h04, 8'h20, 1'b0, -1);
            push_pkt(1, 8'h05, 8'h30, 1'b0, -1);
            push_pkt(0, 8'h06, 8'h40, 1'b0, -1);
            wait_bytes(s + 9 * (r + 1), "rr");
            step();
            step();
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (glog[(g0 + i) & 63] !== exp_g[i]) begin
                n_bad++;
                $display("FAIL rr_order%0d: got %0d want %0d", i, glog[(g0 + i) & 63], exp_g[i]);
            end
        end
        n_cmp++;
        if (gl_n != g0 + 6 || cap_n != s + 18 || perr_n != pe) begin
            n_bad++;
            $display("FAIL rr_counts: got grants=%0d bytes=%0d perr=%0d want 6/18/0",
                     gl_n - g0, cap_n - s, perr_n - pe);
        end
    endtask

    task automatic test_zero_len();
        int s, pe;
        s  = cap_n;
        pe = perr_n;
        push_pkt(0, 8'h02, 8'h00, 1'b0, -1);
        wait_bytes(s + 2, "zero");
        step();
        step();
        check_bytes(s, "zero");
        n_cmp++;
        if (cap_n != s + 2 || perr_n != pe) begin
            n_bad++;
            $display("FAIL zero_counts: got bytes=%0d perr=%0d want 2/0", cap_n - s, perr_n - pe);
        end
        push_pkt(2, 8'h01, 8'h00, 1'b1, -1);
        wait_bytes(s + 4, "badpar");
        step();
        step();
        step();
        n_cmp++;
        if (perr_n != pe + 1) begin
            n_bad++;
            $display("FAIL badpar_pulses: got %0d want 1", perr_n - pe);
        end
        n_cmp++;
        if (perr_byte !== 8'hFE) begin
            n_bad++;
            $display("FAIL badpar_in_done: got %h want fe", perr_byte);
        end
    endtask

    task automatic test_link_toggle();
        int s, v0, pe;
        s  = cap_n;
        v0 = viol;
        pe = perr_n;
        push_pkt(0, 8'h29, 8'h50, 1'b0, -1);
        for (int k = 0; k < 200; k++) begin
            if (cap_n >= s + 12) break;
            link_ready = ~link_ready;
            step();
        end
        link_ready = 1'b1;
        step();
        step();
        step();
        check_bytes(s, "toggle");
        n_cmp++;
        if (cap_n != s + 12 || viol != v0 || perr_n != pe) begin
            n_bad++;
            $display("FAIL toggle_counts: got bytes=%0d strobe_viol=%0d perr=%0d want 12/0/0",
                     cap_n - s, viol - v0, perr_n - pe);
        end
    endtask

    task automatic test_timeout();
        int s, pe, sr0, sr1, sr2;
        s   = cap_n;
        pe  = perr_n;
        sr0 = sr_n[0];
        sr1 = sr_n[1];
        sr2 = sr_n[2];
        push_pkt(2, 8'h14, 8'h60, 1'b0, 3);
        for (int k = 0; k < 150; k++) begin
            if (sr_n[2] != sr2) break;
            link_ready = ~link_ready;
            step();
        end
        link_ready = 1'b1;
        n_cmp++;
        if (sr_n[2] != sr2 + 1) begin
            n_bad++;
            $display("FAIL tmo_pulse: got %0d pulses want 1", sr_n[2] - sr2);
        end
        n_cmp++;
        if (sr_cyc - e2_rise != 31) begin
            n_bad++;
            $display("FAIL tmo_cycle: got empty cycle %0d want 32", sr_cyc - e2_rise + 1);
        end
        n_cmp++;
        if (grant !== 2'b11 || vld_out !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_idle: got grant=%b vld=%b want 11/0", grant, vld_out);
        end
        step();
        step();
        n_cmp++;
        if (sr_n[2] != sr2 + 1 || sr_n[0] != sr0 || sr_n[1] != sr1 || perr_n != pe || cap_n != s + 3) begin
            n_bad++;
            $display("FAIL tmo_side: got sr2=%0d sr0=%0d sr1=%0d perr=%0d bytes=%0d want 1/0/0/0/3",
                     sr_n[2] - sr2, sr_n[0] - sr0, sr_n[1] - sr1, perr_n - pe, cap_n - s);
        end
    endtask

    task automatic test_reset_mid();
        int s, g0, sr_tot;
        do_reset();
        s = cap_n;
        push_pkt(0, 8'h04, 8'h70, 1'b0, -1);
        wait_bytes(s + 3, "pre");
        step();
        step();
        s = cap_n;
        push_pkt(1, 8'h14, 8'h80, 1'b0, -1);
        wait_bytes(s + 2, "mid");
        sr_tot = sr_n[0] + sr_n[1] + sr_n[2];
        resetn = 1'b0;
        flush  = 1'b1;
        step();
        check_idle_outputs("midreset_state");
        resetn = 1'b1;
        flush  = 1'b0;
        step();
        check_idle_outputs("midreset_after");
        s  = cap_n;
        g0 = gl_n;
        push_pkt(1, 8'h04, 8'h90, 1'b0, -1);
        push_pkt(0, 8'h08, 8'hA0, 1'b0, -1);
        wait_bytes(s + 7, "post");
        step();
        step();
        check_bytes(s, "post_fifo0");
        n_cmp++;
        if (glog[g0 & 63] !== 2'd0 || glog[(g0 + 1) & 63] !== 2'd1) begin
            n_bad++;
            $display("FAIL post_order: got %0d,%0d want 0,1", glog[g0 & 63], glog[(g0 + 1) & 63]);
        end
        n_cmp++;
        if (sr_n[0] + sr_n[1] + sr_n[2] != sr_tot) begin
            n_bad++;
            $display("FAIL midreset_softreset: got %0d pulses want 0", sr_n[0] + sr_n[1] + sr_n[2] - sr_tot);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        link_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_link_toggle();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
